branch_predictor: RTL and testbench

- Fetch-stage direction/target predictor: gshare PHT of 2-bit saturating counters, direct-mapped BTB with branch type, and a return address stack (RAS).
- Lookup happens in the fetch stage. Training comes from the execute-stage branch resolution update bus.
- Saturating counter arithmetic replaces the previous wrapping update. Also adds global history, call/return handling, parametrised depths and an init sweep.

---
 rtl/branch_predictor.sv | 256 +++++++++++++++++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage direction and target predictor.
//   - gshare PHT of 2-bit saturating counters, indexed by pc[PHT_IDX_W+1:2] ^ GHR
//   - direct-mapped BTB holding tag, target and branch type
//   - return address stack (RAS) for call/return pairs
// After reset, the init FSM sweeps every PHT entry to weakly-not-taken (2'b01).
// Until that finishes, lookups and updates are ignored.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   init_done_o        high once the PHT sweep is complete
//   dbg_init_state_o   init FSM state (0 = INIT, 1 = RUN)
//   fe_*               fetch lookup request
//   pred_*             combinational lookup result plus the GHR/RAS snapshots
//                      that travel down the pipe with the branch
//   upd_*              resolved-branch training/recovery bus from execute
//
// Handshake: fe_valid_i and upd_valid_i are single-cycle qualifiers; there is
// no back-pressure. Each is consumed at the posedge where it is high, and only
// once init_done_o is set.
module branch_predictor #(
  parameter int PC_W      = 32,
  parameter int PHT_IDX_W = 10,
  parameter int BTB_IDX_W = 6,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic                                init_done_o,
  output logic                                dbg_init_state_o,
  input  logic                                fe_valid_i,
  input  logic [PC_W-1:0]                     fe_pc_i,
  output logic                                pred_taken_o,
  output logic                                pred_hit_o,
  output logic [PC_W-1:0]                     pred_target_o,
  output logic [1:0]                          pred_state_o,
  output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] pred_ghr_o,
  output logic [$clog2(RAS_DEPTH)-1:0]        pred_ras_ptr_o,
  input  logic                                upd_valid_i,
  input  logic [PC_W-1:0]                     upd_pc_i,
  input  logic [1:0]                          upd_type_i,
  input  logic                                upd_taken_i,
  input  logic [PC_W-1:0]                     upd_target_i,
  input  logic [1:0]                          upd_state_i,
  input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0] upd_ghr_i,
  input  logic [$clog2(RAS_DEPTH)-1:0]        upd_ras_ptr_i,
  input  logic                                upd_mispredict_i
);

  // With GHR_W = 0 the history register is kept one bit wide but held at zero,
  // so the PHT index reduces to the PC bits alone.
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam int RP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = RP_W + 1;
  localparam int TAG_W = PC_W - BTB_IDX_W - 2;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;

  typedef enum logic [1:0] {BR_COND = 2'd0, BR_JUMP = 2'd1, BR_CALL = 2'd2, BR_RET = 2'd3} br_type_e;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} init_state_e;

  init_state_e            init_state;
  logic [PHT_IDX_W-1:0]   init_cnt;
  logic [GW-1:0]          ghr;
  logic [RP_W-1:0]        ras_ptr;
  logic [CNT_W-1:0]       ras_cnt;
  logic [BTB_N-1:0]       btb_valid;

  logic [1:0]             pht        [PHT_N];
  logic [TAG_W-1:0]       btb_tag    [BTB_N];
  logic [PC_W-1:0]        btb_target [BTB_N];
  br_type_e               btb_type   [BTB_N];
  logic [PC_W-1:0]        ras        [RAS_DEPTH];

  // ---------------- lookup (combinational, reads registered state) --------
  logic [PHT_IDX_W-1:0] lk_pht_idx;
  logic [BTB_IDX_W-1:0] lk_btb_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;
  br_type_e             lk_type;
  logic [1:0]           lk_state;
  logic [PC_W-1:0]      lk_seq;
  logic [RP_W-1:0]      ras_top;
  logic                 lk_taken;
  logic [PC_W-1:0]      lk_target;

  assign lk_pht_idx = fe_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign lk_btb_idx = fe_pc_i[BTB_IDX_W+1:2];
  assign lk_tag     = fe_pc_i[PC_W-1:BTB_IDX_W+2];
  assign lk_hit     = btb_valid[lk_btb_idx] && (btb_tag[lk_btb_idx] == lk_tag);
  assign lk_type    = btb_type[lk_btb_idx];
  assign lk_state   = pht[lk_pht_idx];
  assign lk_seq     = fe_pc_i + PC_W'(4);
  assign ras_top    = ras_ptr - RP_W'(1);

  always_comb begin
    lk_taken = 1'b0;
    case (lk_type)
      BR_COND:          lk_taken = lk_hit && lk_state[1];
      BR_JUMP, BR_CALL: lk_taken = lk_hit;
      BR_RET:           lk_taken = lk_hit && (ras_cnt != '0);
      default:          lk_taken = 1'b0;
    endcase
  end

  assign lk_target = !lk_taken          ? lk_seq :
                     (lk_type == BR_RET) ? ras[ras_top] : btb_target[lk_btb_idx];

  // While sweeping, everything reads as zero and fetch falls through.
  assign pred_taken_o     = init_done_o && lk_taken;
  assign pred_hit_o       = init_done_o && lk_hit;
  assign pred_target_o    = init_done_o ? lk_target : lk_seq;
  assign pred_state_o     = init_done_o ? lk_state : 2'b00;
  assign pred_ghr_o       = init_done_o ? ghr : '0;
  assign pred_ras_ptr_o   = init_done_o ? ras_ptr : '0;
  assign dbg_init_state_o = init_state;

  // ---------------- update / recovery --------------------------------------
  logic [PHT_IDX_W-1:0] upd_pht_idx;
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic [TAG_W-1:0]     upd_tag;
  br_type_e             upd_type;
  logic                 upd_en, upd_cond, recover, spec_en, btb_wr;
  logic [1:0]           upd_ctr_next;

  assign upd_pht_idx = upd_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr_i);
  assign upd_btb_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign upd_tag     = upd_pc_i[PC_W-1:BTB_IDX_W+2];
  assign upd_type    = br_type_e'(upd_type_i);
  assign upd_en      = upd_valid_i && init_done_o;
  assign upd_cond    = (upd_type == BR_COND);
  assign recover     = upd_en && upd_mispredict_i;
  assign spec_en     = fe_valid_i && init_done_o && lk_hit;

  // Saturating counter: 3 stays 3 on taken, 0 stays 0 on not-taken.
  assign upd_ctr_next = upd_taken_i ? ((upd_state_i == 2'd3) ? 2'd3 : upd_state_i + 2'd1)
                                    : ((upd_state_i == 2'd0) ? 2'd0 : upd_state_i - 2'd1);

  // Only taken branches allocate; an existing identical entry is left alone.
  assign btb_wr = upd_en && upd_taken_i &&
                  (!btb_valid[upd_btb_idx] || (btb_tag[upd_btb_idx] != upd_tag) ||
                   (btb_target[upd_btb_idx] != upd_target_i) || (btb_type[upd_btb_idx] != upd_type));

  logic                 pht_we;
  logic [PHT_IDX_W-1:0] pht_widx;
  logic [1:0]           pht_wdata;

  assign pht_we    = (init_state == ST_INIT) || (upd_en && upd_cond);
  assign pht_widx  = (init_state == ST_INIT) ? init_cnt : upd_pht_idx;
  assign pht_wdata = (init_state == ST_INIT) ? 2'b01 : upd_ctr_next;

  // Recovery has priority over the speculative change from the same cycle.
  logic [GW-1:0] ghr_next;
  always_comb begin
    ghr_next = ghr;
    if (recover)
      ghr_next = upd_cond ? GW'({upd_ghr_i, upd_taken_i}) : upd_ghr_i;
    else if (spec_en && (lk_type == BR_COND))
      ghr_next = GW'({ghr, lk_taken});
  end

  // No count snapshot travels with the branch, so on recovery the live count
  // is stepped by the resolved branch's call/return effect, clamped to range.
  logic [RP_W-1:0]  ras_ptr_next, push_idx;
  logic [CNT_W-1:0] ras_cnt_next, cnt_inc, cnt_dec;
  logic             push_en;
  logic [PC_W-1:0]  push_data;

  assign cnt_inc = (ras_cnt == CNT_W'(RAS_DEPTH)) ? ras_cnt : ras_cnt + CNT_W'(1);
  assign cnt_dec = (ras_cnt == '0) ? ras_cnt : ras_cnt - CNT_W'(1);

  always_comb begin
    ras_ptr_next = ras_ptr;
    ras_cnt_next = ras_cnt;
    push_en      = 1'b0;
    push_idx     = ras_ptr;
    push_data    = lk_seq;
    if (recover) begin
      case (upd_type)
        BR_CALL: begin
          ras_ptr_next = upd_ras_ptr_i + RP_W'(1);
          ras_cnt_next = cnt_inc;
          push_en      = 1'b1;
          push_idx     = upd_ras_ptr_i;
          push_data    = upd_pc_i + PC_W'(4);
        end
        BR_RET: begin
          ras_ptr_next = upd_ras_ptr_i - RP_W'(1);
          ras_cnt_next = cnt_dec;
        end
        default: ras_ptr_next = upd_ras_ptr_i;
      endcase
    end else if (spec_en) begin
      case (lk_type)
        BR_CALL: begin
          // Wrapping pointer: a push into a full stack overwrites the oldest entry.
          ras_ptr_next = ras_ptr + RP_W'(1);
          ras_cnt_next = cnt_inc;
          push_en      = 1'b1;
        end
        BR_RET: begin
          if (ras_cnt != '0) begin
            ras_ptr_next = ras_top;
            ras_cnt_next = cnt_dec;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- control state and init FSM -----------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_state  <= ST_INIT;
      init_cnt    <= '0;
      init_done_o <= 1'b0;
      ghr         <= '0;
      ras_ptr     <= '0;
      ras_cnt     <= '0;
      btb_valid   <= '0;
    end else begin
      case (init_state)
        ST_INIT: begin
          init_cnt <= init_cnt + PHT_IDX_W'(1);
          if (init_cnt == '1) begin
            init_state  <= ST_RUN;
            init_done_o <= 1'b1;
          end
        end
        ST_RUN:  init_done_o <= 1'b1;
        default: init_state  <= ST_INIT;
      endcase
      if (GHR_W > 0) ghr <= ghr_next;
      ras_ptr <= ras_ptr_next;
      ras_cnt <= ras_cnt_next;
      if (btb_wr) btb_valid[upd_btb_idx] <= 1'b1;
    end
  end

  // Storage arrays: contents need no reset (PHT is swept, BTB is guarded by valid).
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_widx] <= pht_wdata;
    if (btb_wr) begin
      btb_tag[upd_btb_idx]    <= upd_tag;
      btb_target[upd_btb_idx] <= upd_target_i;
      btb_type[upd_btb_idx]   <= upd_type;
    end
    if (push_en) ras[push_idx] <= push_data;
  end

  // Byte-offset bits of word-aligned PCs carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, fe_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  localparam logic [1:0] T_COND = 2'd0, T_JUMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done_o, dbg_init_state_o;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic [7:0]  pred_ghr;
  logic [2:0]  pred_ras_ptr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [1:0]  upd_type, upd_state;
  logic [7:0]  upd_ghr;
  logic [2:0]  upd_ras_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  state;
  } vec_t;
  vec_t vecs[7];

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .init_done_o(init_done_o), .dbg_init_state_o(dbg_init_state_o),
    .fe_valid_i(fe_valid), .fe_pc_i(fe_pc),
    .pred_taken_o(pred_taken), .pred_hit_o(pred_hit), .pred_target_o(pred_target),
    .pred_state_o(pred_state), .pred_ghr_o(pred_ghr), .pred_ras_ptr_o(pred_ras_ptr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_type_i(upd_type), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_state_i(upd_state), .upd_ghr_i(upd_ghr),
    .upd_ras_ptr_i(upd_ras_ptr), .upd_mispredict_i(upd_mispredict)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_upd();
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                           input logic [31:0] tgt, input logic [1:0] st, input logic [7:0] gh,
                           input logic [2:0] rp, input logic mp);
    upd_pc = pc; upd_type = typ; upd_taken = tk; upd_target = tgt;
    upd_state = st; upd_ghr = gh; upd_ras_ptr = rp; upd_mispredict = mp;
    upd_valid = 1'b1;
  endtask

  task automatic train(input logic [31:0] pc, input logic [1:0] typ, input logic tk,
                       input logic [31:0] tgt, input logic [1:0] st);
    drive_upd(pc, typ, tk, tgt, st, 8'h00, 3'd0, 1'b0);
    step();
    clear_upd();
  endtask

  task automatic peek(input logic [31:0] pc);
    fe_pc = pc;
    fe_valid = 1'b0;
    #1;
  endtask

  task automatic look_check(input string name, input logic [31:0] pc, input logic hit,
                            input logic tk, input logic [31:0] tgt, input logic [1:0] st);
    peek(pc);
    check({name, "_hit"},    pred_hit,    hit);
    check({name, "_taken"},  pred_taken,  tk);
    check({name, "_target"}, pred_target, tgt);
    check({name, "_state"},  pred_state,  st);
  endtask

  // ---------------- test ----------------
  initial begin
    int cycles;
    int exp_ptr;
    logic [1:0] exp_st;
    logic [31:0] cpc;
    logic [31:0] ppc;

    vecs[0] = '{32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_0200, 2'd2};
    vecs[1] = '{32'h1C00_0104, 1'b0, 1'b0, 32'h1C00_0108, 2'd1};
    vecs[2] = '{32'h0C00_0100, 1'b0, 1'b0, 32'h0C00_0104, 2'd2};
    vecs[3] = '{32'h0000_0A10, 1'b1, 1'b1, 32'h0000_0F40, 2'd1};
    vecs[4] = '{32'h0000_0A20, 1'b1, 1'b0, 32'h0000_0A24, 2'd1};
    vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 2'd1};
    vecs[6] = '{32'h1C00_0A00, 1'b0, 1'b0, 32'h1C00_0A04, 2'd0};

    rst_n = 1'b0; fe_valid = 1'b0; fe_pc = '0;
    upd_pc = '0; upd_type = '0; upd_taken = 1'b0; upd_target = '0;
    upd_state = '0; upd_ghr = '0; upd_ras_ptr = '0;
    clear_upd();
    step();
    check("reset_init_done", init_done_o, 1'b0);
    check("reset_fsm_state", dbg_init_state_o, 1'b0);
    rst_n = 1'b1;

    // INIT: outputs forced, fetch and update traffic ignored
    fe_pc = 32'h0000_0040; #1;
    check("init_taken",  pred_taken,   1'b0);
    check("init_hit",    pred_hit,     1'b0);
    check("init_target", pred_target,  32'h0000_0044);
    check("init_state",  pred_state,   2'd0);
    check("init_ghr",    pred_ghr,     8'h00);
    check("init_ras",    pred_ras_ptr, 3'd0);
    fe_valid = 1'b1;
    drive_upd(32'h5000_0040, T_COND, 1'b1, 32'h5000_0800, 2'd1, 8'hFF, 3'd3, 1'b1);
    repeat (3) step();
    clear_upd(); fe_valid = 1'b0;
    repeat (497) step();
    check("mid_init_done", init_done_o, 1'b0);

    // reset mid-sweep restarts from entry 0
    rst_n = 1'b0; step(); rst_n = 1'b1;
    cycles = 0;
    while (!init_done_o && cycles < 2000) begin
      step();
      cycles++;
    end
    check("init_sweep_cycles", cycles, 1024);
    check("run_fsm_state", dbg_init_state_o, 1'b1);
    check("post_init_ghr", pred_ghr, 8'h00);
    check("post_init_ras", pred_ras_ptr, 3'd0);
    look_check("ignored_init_upd", 32'h5000_0040, 1'b0, 1'b0, 32'h5000_0044, 2'd1);

    for (int i = 0; i < 1024; i++) begin
      peek(i << 2);
      check("sweep_state", pred_state, 2'd1);
      check("sweep_hit", pred_hit, 1'b0);
      check("sweep_target", pred_target, (i << 2) + 4);
    end

    // conditional branch: allocate, then saturate
    train(32'h1C00_0100, T_COND, 1'b1, 32'h1C00_0200, 2'd1);
    look_check("cond_first", 32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_0200, 2'd2);
    exp_st = 2'd2;
    for (int k = 0; k < 4; k++) begin
      train(32'h1C00_0100, T_COND, 1'b1, 32'h1C00_0200, exp_st);
      exp_st = (exp_st == 2'd3) ? 2'd3 : exp_st + 2'd1;
      peek(32'h1C00_0100);
      check("cond_sat_hi", pred_state, exp_st);
    end
    train(32'h1C00_0100, T_COND, 1'b0, 32'h1C00_0200, 2'd3);
    look_check("cond_nt_keep", 32'h1C00_0100, 1'b1, 1'b1, 32'h1C00_0200, 2'd2);
    train(32'h1C00_0A00, T_COND, 1'b0, 32'h0, 2'd1);
    peek(32'h1C00_0A00);
    check("cond_dec", pred_state, 2'd0);
    train(32'h1C00_0A00, T_COND, 1'b0, 32'h0, 2'd0);
    peek(32'h1C00_0A00);
    check("cond_sat_lo", pred_state, 2'd0);

    // table of lookups after a few more trainings (incl. a retarget)
    train(32'h0000_0A10, T_JUMP, 1'b1, 32'h0000_0F00, 2'd1);
    train(32'h0000_0A20, T_COND, 1'b1, 32'h0000_0B00, 2'd0);
    train(32'h0000_0A10, T_JUMP, 1'b1, 32'h0000_0F40, 2'd1);
    for (int v = 0; v < 7; v++)
      look_check($sformatf("vec%0d", v), vecs[v].pc, vecs[v].hit, vecs[v].taken,
                 vecs[v].target, vecs[v].state);

    // call / return
    train(32'h0000_0100, T_CALL, 1'b1, 32'h0000_0400, 2'd1);
    train(32'h0000_0404, T_RET,  1'b1, 32'h0000_0104, 2'd1);
    exp_ptr = 0;
    fe_pc = 32'h0000_0100; fe_valid = 1'b1; #1;
    check("call_taken", pred_taken, 1'b1);
    check("call_target", pred_target, 32'h0000_0400);
    check("call_ptr", pred_ras_ptr, exp_ptr);
    step(); fe_valid = 1'b0;
    exp_q.push_back(32'h0000_0104); exp_ptr = (exp_ptr + 1) % 8;
    look_check("ret_pred", 32'h0000_0404, 1'b1, 1'b1, exp_q[$], 2'd1);
    check("ret_ptr", pred_ras_ptr, exp_ptr);
    fe_valid = 1'b1; step(); fe_valid = 1'b0;
    void'(exp_q.pop_back()); exp_ptr = (exp_ptr + 7) % 8;
    look_check("ret_empty", 32'h0000_0404, 1'b1, 1'b0, 32'h0000_0408, 2'd1);
    fe_valid = 1'b1; step(); fe_valid = 1'b0; #1;
    check("ret_empty_ptr", pred_ras_ptr, exp_ptr);

    // nine nested calls into an 8-deep stack
    for (int k = 0; k < 9; k++) train(32'h0000_1008 + k * 16, T_CALL, 1'b1, 32'h0000_8000, 2'd1);
    for (int k = 0; k < 9; k++) begin
      cpc = 32'h0000_1008 + k * 16;
      fe_pc = cpc; fe_valid = 1'b1; #1;
      check("nest_call_taken", pred_taken, 1'b1);
      step();
      exp_q.push_back(cpc + 4);
      if (exp_q.size() > 8) void'(exp_q.pop_front());
      exp_ptr = (exp_ptr + 1) % 8;
    end
    fe_valid = 1'b0; #1;
    check("nest_ptr", pred_ras_ptr, exp_ptr);
    for (int k = 0; k < 9; k++) begin
      fe_pc = 32'h0000_0404; fe_valid = 1'b1; #1;
      if (exp_q.size() > 0) begin
        check("pop_taken", pred_taken, 1'b1);
        check("pop_target", pred_target, exp_q.pop_back());
        exp_ptr = (exp_ptr + 7) % 8;
      end else begin
        check("pop_empty_taken", pred_taken, 1'b0);
        check("pop_empty_target", pred_target, 32'h0000_0408);
      end
      step();
    end
    fe_valid = 1'b0; #1;
    check("pop_ptr", pred_ras_ptr, exp_ptr);

    // speculative history and gshare indexing
    ppc = 32'h2000_00C0;
    train(ppc, T_COND, 1'b1, 32'h2000_0400, 2'd1);
    fe_pc = ppc; fe_valid = 1'b1; #1;
    check("spec1_state", pred_state, 2'd2);
    check("spec1_taken", pred_taken, 1'b1);
    step(); fe_valid = 1'b0; #1;
    check("spec1_ghr", pred_ghr, 8'h01);
    check("spec2_state", pred_state, 2'd1);
    check("spec2_taken", pred_taken, 1'b0);
    fe_valid = 1'b1; step(); fe_valid = 1'b0; #1;
    check("spec2_ghr", pred_ghr, 8'h02);

    // recovery overrides same-cycle speculation
    fe_pc = ppc; fe_valid = 1'b1;
    drive_upd(ppc, T_COND, 1'b1, 32'h2000_0400, 2'd1, 8'hA5, 3'd5, 1'b1);
    step(); clear_upd(); fe_valid = 1'b0; #1;
    check("recov_cond_ghr", pred_ghr, 8'h4B);
    check("recov_cond_ptr", pred_ras_ptr, 3'd5);
    fe_pc = 32'h0000_0100; fe_valid = 1'b1;
    drive_upd(32'h7000_0000, T_JUMP, 1'b0, 32'h0, 2'd0, 8'h3C, 3'd2, 1'b1);
    step(); clear_upd(); fe_valid = 1'b0; #1;
    check("recov_jump_ghr", pred_ghr, 8'h3C);
    check("recov_jump_ptr", pred_ras_ptr, 3'd2);
    drive_upd(32'h7000_0000, T_CALL, 1'b0, 32'h0, 2'd0, 8'h11, 3'd7, 1'b1);
    step(); clear_upd(); #1;
    check("recov_call_ghr", pred_ghr, 8'h11);
    check("recov_call_ptr", pred_ras_ptr, 3'd0);
    drive_upd(32'h7000_0000, T_RET, 1'b0, 32'h0, 2'd0, 8'h00, 3'd0, 1'b1);
    step(); clear_upd(); #1;
    check("recov_ret_ptr", pred_ras_ptr, 3'd7);
    drive_upd(32'h7000_0000, T_COND, 1'b0, 32'h0, 2'd1, 8'h81, 3'd3, 1'b1);
    step(); clear_upd(); #1;
    check("recov_nt_ghr", pred_ghr, 8'h02);
    check("recov_nt_ptr", pred_ras_ptr, 3'd3);

    // same-cycle lookup and update of one entry: read-before-write
    fe_pc = 32'h3000_0300; fe_valid = 1'b0;
    drive_upd(32'h3000_0300, T_COND, 1'b1, 32'h3000_0500, 2'd1, 8'h02, 3'd0, 1'b0);
    #1;
    check("rbw_old_state", pred_state, 2'd1);
    check("rbw_old_hit", pred_hit, 1'b0);
    step(); clear_upd(); #1;
    check("rbw_new_state", pred_state, 2'd2);
    check("rbw_new_hit", pred_hit, 1'b1);
    check("rbw_new_target", pred_target, 32'h3000_0500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
